button_conditioner: RTL

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner_pkg.sv | 14 +
 rtl/button_conditioner_debounce_channel.sv | 62 ++++++
 rtl/button_conditioner.sv | 70 +++++++
 3 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared game constants: debounce defaults and the debounce counter type.
// Imported by the button conditioner and its debounce channels. The paddle
// and ball blocks use it as well.
package button_conditioner_pkg;

   // Number of consecutive differing frame samples needed to accept a new level.
   localparam int unsigned DEBOUNCE_FRAMES_DEFAULT = 3;

   // Width of the per-channel debounce counter. It covers DEBOUNCE_FRAMES up to 15.
   localparam int unsigned DEB_CNT_W = 4;

   typedef logic [DEB_CNT_W-1:0] deb_cnt_t;

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// debounce_channel: one button channel. It contains a 2-flop synchronizer,
// a frame-rate debouncer with stable level S and counter C, and a rise strobe.
//   clk         : system/pixel clock, rising edge
//   nRst        : asynchronous active-low reset
//   frame_pulse : debounce sampling tick; one sample per clk while high
//   i_raw       : asynchronous raw pad, active-high
//   o_stable    : accepted (debounced) level S, registered
//   o_rise      : combinational strobe, high in the cycle that S will rise 0->1
module debounce_channel
   import button_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEFAULT
)(
   input  logic clk,
   input  logic nRst,
   input  logic frame_pulse,
   input  logic i_raw,
   output logic o_stable,
   output logic o_rise
);

   localparam deb_cnt_t LAST_CNT = deb_cnt_t'(DEBOUNCE_FRAMES - 1);

   logic     r_meta;
   logic     r_sync;
   logic     r_stable;
   deb_cnt_t r_cnt;

   logic     w_differ;
   logic     w_accept;

   assign w_differ = r_sync ^ r_stable;
   assign w_accept = frame_pulse & w_differ & (r_cnt == LAST_CNT);

   // The strobe is taken ahead of the S register so that a registered press in
   // the parent lines up with the cycle where S is first seen high.
   assign o_rise   = w_accept & r_sync;
   assign o_stable = r_stable;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_meta   <= 1'b0;
         r_sync   <= 1'b0;
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_meta <= i_raw;
         r_sync <= r_meta;
         if (frame_pulse) begin
            if (!w_differ) begin
               r_cnt <= '0;               // glitch rejected, count restarts
            end else if (w_accept) begin
               r_stable <= r_sync;
               r_cnt    <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounces the left and right paddle buttons. The two
// directions are mutually exclusive. It also produces a one-clk press pulse
// (serve/launch) on any accepted press.
//   clk           : system/pixel clock, rising edge
//   nRst          : asynchronous active-low reset (release synchronous externally)
//   frame_pulse   : one-clk strobe per video frame, debounce sampling tick
//   btn_left_raw  : raw left pad, asynchronous, active-high
//   btn_right_raw : raw right pad, asynchronous, active-high
//   button_left   : debounced left command (low when both are accepted)
//   button_right  : debounced right command (low when both are accepted)
//   button_press  : one-clk pulse after any accepted 0->1 level
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEFAULT
)(
   input  logic clk,
   input  logic nRst,
   input  logic frame_pulse,
   input  logic btn_left_raw,
   input  logic btn_right_raw,
   output logic button_left,
   output logic button_right,
   output logic button_press
);

   logic w_stable_l;
   logic w_stable_r;
   logic w_rise_l;
   logic w_rise_r;
   logic r_press;

   debounce_channel #(
      .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
   ) u_left (
      .clk         (clk),
      .nRst        (nRst),
      .frame_pulse (frame_pulse),
      .i_raw       (btn_left_raw),
      .o_stable    (w_stable_l),
      .o_rise      (w_rise_l)
   );

   debounce_channel #(
      .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
   ) u_right (
      .clk         (clk),
      .nRst        (nRst),
      .frame_pulse (frame_pulse),
      .i_raw       (btn_right_raw),
      .o_stable    (w_stable_r),
      .o_rise      (w_rise_r)
   );

   // When both buttons are accepted, neither command is driven and the paddle holds.
   assign button_left  = w_stable_l & ~w_stable_r;
   assign button_right = w_stable_r & ~w_stable_l;

   // If both channels rise together, the OR merges them into a single pulse.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_press <= 1'b0;
      end else begin
         r_press <= w_rise_l | w_rise_r;
      end
   end

   assign button_press = r_press;

endmodule
